// File: rtl/ooop_types.sv
// rtl/ooop_types.sv - shared core types: trace monitor states, halt causes and trace record
package ooop_types;
  localparam int TRACE_NUM_WATCH = 2;
  localparam int TRACE_XLEN      = 32;
  localparam int TRACE_CNT_W     = 32;

  typedef enum logic [1:0] {
    TK_PERIODIC   = 2'd0,
    TK_STALL_SNAP = 2'd1,
    TK_FINAL      = 2'd2
  } trace_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } mon_state_e;

  typedef enum logic [1:0] {
    HC_NONE   = 2'd0,
    HC_STALL  = 2'd1,
    HC_MAXCYC = 2'd2
  } halt_cause_e;

  typedef struct packed {
    trace_kind_e                           kind;
    logic [TRACE_CNT_W-1:0]                cycle;
    logic [TRACE_CNT_W-1:0]                commits;
    logic [TRACE_NUM_WATCH*TRACE_XLEN-1:0] vals;
  } trace_rec_t;

  localparam int TRACE_REC_W = $bits(trace_rec_t);

  function automatic logic [TRACE_CNT_W-1:0] sat_inc(input logic [TRACE_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - synchronous first-word-fall-through FIFO; head reads as zero when empty
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_tvalid,
  input  logic [WIDTH-1:0]         in_tdata,
  output logic [WIDTH-1:0]         out_tdata,
  input  logic                     out_tready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = in_tvalid && !full;
  assign do_pop    = out_tready && !empty;
  assign out_tdata = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= in_tdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/core_trace_mon.sv
// rtl/core_trace_mon.sv - commit-progress monitor and watched-value tracer; OOOP_TRACE_STALL_SNAP_EN adds mid-stall snapshots
module core_trace_mon
  import ooop_types::*;
#(
  parameter int XLEN            = 32,
  parameter int NUM_WATCH       = 2,
  parameter int COMMIT_W        = 1,
  parameter int SAMPLE_EVERY    = 1,
  parameter int STALL_THRESHOLD = 200,
  parameter int MAX_CYCLES      = 300,
  parameter int FIFO_DEPTH      = 8,
  parameter int CNT_W           = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable_i,
  input  logic [$clog2(COMMIT_W+1)-1:0]   commit_cnt_i,
  input  logic [NUM_WATCH*XLEN-1:0]       watch_val_i,
  output logic                            trace_valid_o,
  input  logic                            trace_ready_i,
  output trace_rec_t                      trace_rec_o,
  output logic [CNT_W-1:0]                cycle_o,
  output logic [CNT_W-1:0]                commits_o,
  output logic [CNT_W-1:0]                stall_ctr_o,
  output logic [CNT_W-1:0]                drop_cnt_o,
  output logic [1:0]                      state_o,
  output logic                            halt_o,
  output logic [1:0]                      halt_cause_o
);
  localparam int SW  = (SAMPLE_EVERY > 1) ? $clog2(SAMPLE_EVERY) : 1;
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [SW-1:0] SAMPLE_RELOAD = SW'(SAMPLE_EVERY - 1);

  mon_state_e        state_q, state_nx;
  halt_cause_e       cause_q, cause_nx;
  logic [CNT_W-1:0]  cycle_q, cycle_nx, commits_q, commits_nx;
  logic [CNT_W-1:0]  stall_q, stall_nx, drop_q, drop_nx;
  logic [SW-1:0]     samp_q, samp_nx;
  logic              push, periodic_due, snap_due, has_space, stall_hit, cyc_hit;
  trace_rec_t        push_rec;
  logic [TRACE_REC_W-1:0] head_data;
  logic [FCW-1:0]    fifo_count;
  logic              fifo_full, fifo_empty;
`ifdef OOOP_TRACE_STALL_SNAP_EN
  logic              snap_armed_q, snap_armed_nx;
`endif

  assign stall_hit = (stall_q >= CNT_W'(STALL_THRESHOLD));
  assign cyc_hit   = (cycle_q >= CNT_W'(MAX_CYCLES));
  // Last slot is kept for the FINAL record; same-cycle pops do not count.
  assign has_space = !fifo_full && (fifo_count < FCW'(FIFO_DEPTH - 1));

  always_comb begin
    state_nx         = state_q;
    cause_nx         = cause_q;
    cycle_nx         = cycle_q;
    commits_nx       = commits_q;
    stall_nx         = stall_q;
    drop_nx          = drop_q;
    samp_nx          = samp_q;
    push             = 1'b0;
    periodic_due     = 1'b0;
    snap_due         = 1'b0;
    push_rec.kind    = TK_PERIODIC;
    push_rec.cycle   = cycle_q;
    push_rec.commits = commits_q;
    push_rec.vals    = watch_val_i;
`ifdef OOOP_TRACE_STALL_SNAP_EN
    snap_armed_nx    = snap_armed_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          state_nx = ST_RUN;
          samp_nx  = SAMPLE_RELOAD;
        end
      end
      ST_RUN: begin
        if (stall_hit || cyc_hit) begin
          state_nx      = ST_HALT;
          cause_nx      = stall_hit ? HC_STALL : HC_MAXCYC;
          push          = 1'b1;
          push_rec.kind = TK_FINAL;
        end else if (enable_i) begin
          cycle_nx = cycle_q + 1'b1;
          if (commit_cnt_i != '0) begin
            commits_nx = commits_q + CNT_W'(commit_cnt_i);
            stall_nx   = '0;
          end else begin
            stall_nx   = sat_inc(stall_q);
          end
          if (samp_q == '0) begin
            samp_nx      = SAMPLE_RELOAD;
            periodic_due = 1'b1;
          end else begin
            samp_nx      = samp_q - 1'b1;
          end
`ifdef OOOP_TRACE_STALL_SNAP_EN
          snap_due = snap_armed_q && (stall_q == CNT_W'(STALL_THRESHOLD / 2));
          if (commit_cnt_i != '0) snap_armed_nx = 1'b1;
          else if (snap_due)      snap_armed_nx = 1'b0;
`endif
          if (snap_due || periodic_due) begin
            if (has_space) begin
              push          = 1'b1;
              push_rec.kind = snap_due ? TK_STALL_SNAP : TK_PERIODIC;
            end else if (!snap_due) begin
              drop_nx = sat_inc(drop_q);
            end
          end
        end
      end
      ST_HALT: ;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cause_q      <= HC_NONE;
      cycle_q      <= '0;
      commits_q    <= '0;
      stall_q      <= '0;
      drop_q       <= '0;
      samp_q       <= '0;
`ifdef OOOP_TRACE_STALL_SNAP_EN
      snap_armed_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_nx;
      cause_q      <= cause_nx;
      cycle_q      <= cycle_nx;
      commits_q    <= commits_nx;
      stall_q      <= stall_nx;
      drop_q       <= drop_nx;
      samp_q       <= samp_nx;
`ifdef OOOP_TRACE_STALL_SNAP_EN
      snap_armed_q <= snap_armed_nx;
`endif
    end
  end

  trace_fifo #(
    .WIDTH (TRACE_REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_tvalid  (push),
    .in_tdata   (push_rec),
    .out_tdata  (head_data),
    .out_tready (trace_ready_i),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign trace_valid_o = !fifo_empty;
  assign trace_rec_o   = trace_rec_t'(head_data);
  assign cycle_o       = cycle_q;
  assign commits_o     = commits_q;
  assign stall_ctr_o   = stall_q;
  assign drop_cnt_o    = drop_q;
  assign state_o       = state_q;
  assign halt_o        = (state_q == ST_HALT);
  assign halt_cause_o  = cause_q;
endmodule

// File: doc/core_trace_mon.md
# core_trace_mon

Synthesizable, parametrised commit-progress monitor and architectural-value tracer for the OoO core. It sits beside `core_top` and counts cycles and commits, supporting multi-commit-per-cycle widths. It runs a stall watchdog and a max-cycle limit, and samples `NUM_WATCH` architectural register values every `SAMPLE_EVERY` cycles into a drainable trace FIFO. On a halt condition it latches a terminal state and a cause, and it always enqueues one final record.

## Interface
- `XLEN`, 32, width of each watched value
- `NUM_WATCH`, 2, number of watched architectural registers (≥1)
- `COMMIT_W`, 1, maximum commits per cycle
- `SAMPLE_EVERY`, 1, sample period in cycles (≥1)
- `STALL_THRESHOLD`, 200, commit-free cycles that trigger a halt (≥2)
- `MAX_CYCLES`, 300, cycle limit
- `FIFO_DEPTH`, 8, trace FIFO entries (power of 2, ≥2)
- `CNT_W`, 32, counter width
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `enable_i`  in  1  run enable; 0 pauses the monitor
- `commit_cnt_i`  in  $clog2(COMMIT_W+1)  instructions committed this cycle
- `watch_val_i`  in  NUM_WATCH*XLEN  packed watched values, register 0 in the LSBs
- `trace_valid_o`  out  1  FIFO head valid
- `trace_ready_i`  in  1  consumer pops the head when valid & ready
- `trace_rec_o`  out  trace_rec_t  head record: {kind, cycle, commits, vals}
- `cycle_o`, `commits_o`, `stall_ctr_o`  out  CNT_W  live counters
- `drop_cnt_o`  out  CNT_W  periodic records dropped because the FIFO was full
- `state_o`  out  2  IDLE=0, RUN=1, HALT=2
- `halt_o`  out  1  state==HALT
- `halt_cause_o`  out  2  NONE=0, STALL=1, MAXCYC=2

## Operation
- Reset values:
  - All counters 0.
  - State IDLE.
  - `halt_o` 0, `halt_cause_o` NONE.
  - FIFO empty, so `trace_valid_o` 0 and `trace_rec_o` 0.
- State transitions:
  - IDLE→RUN on the first edge with `enable_i`=1.
  - In RUN with `enable_i`=0, all counters and the sample counter hold and no pushes occur.
- Each enabled RUN edge:
  - `cycle` increments by 1.
  - If `commit_cnt_i`≠0: `commits += commit_cnt_i` and `stall_ctr` clears to 0.
  - Otherwise `stall_ctr` increments, saturating at all-ones.
  - All counter arithmetic wraps at CNT_W, except `stall_ctr` and `drop_cnt`, which saturate.
- Sampling:
  - A down-counter is loaded with SAMPLE_EVERY-1 on RUN entry; no modulo logic.
  - At zero it pushes a PERIODIC record (kind 0) and reloads.
  - The record captures the pre-edge `cycle` and `commits` and the current `watch_val_i`.
- Halt check, evaluated on registered counters while in RUN:
  - `stall_ctr >= STALL_THRESHOLD` → cause STALL.
  - `cycle >= MAX_CYCLES` → cause MAXCYC.
  - If both hold, STALL wins.
  - On a halt: next state is HALT and a FINAL record (kind 2) is pushed instead of any periodic record that cycle.
- HALT is terminal until reset:
  - Counters freeze and no further pushes occur.
  - The FIFO keeps draining.
- FIFO space:
  - PERIODIC pushes are accepted only when the registered count < FIFO_DEPTH-1.
  - The last slot is reserved for FINAL, so FINAL is never lost.
  - A rejected PERIODIC record increments `drop_cnt`.
  - A pop in the same cycle does not free space for that cycle's push.

## Timing
- Push at edge N → `trace_valid_o` is visible after edge N. The FIFO is first-word-fall-through, with `trace_rec_o` driven combinationally from the head storage.
- Pop is effective at the edge where valid & ready; the next head appears after that edge.
- `halt_o` and `halt_cause_o` rise one edge after the threshold condition becomes true on the counters.
- A reset asserted mid-run returns every output to its reset value after that edge and discards FIFO contents.

## Configuration
- Macro `OOOP_TRACE_STALL_SNAP_EN`, defined:
  - When `stall_ctr` reaches STALL_THRESHOLD/2, push one STALL_SNAP record (kind 1), subject to the same space rule as PERIODIC.
  - Exactly one such record per stall episode; the trigger re-arms when `commit_cnt_i`≠0.
  - STALL_SNAP takes precedence over a PERIODIC record in the same cycle.
- Macro not defined: kind 1 is never produced and the arming logic is absent.

## Structure
- Add to `ooop_types`:
  - `trace_kind_e` (PERIODIC, STALL_SNAP, FINAL)
  - `mon_state_e`
  - `halt_cause_e`
  - `trace_rec_t`, a struct parametrised via package constants `TRACE_NUM_WATCH` and `TRACE_CNT_W`.
- Sub-module `trace_fifo`: synchronous FWFT FIFO with parameters WIDTH and DEPTH; it exposes `count`, `full` and `empty`.

## Test plan
- MAX_CYCLES=20, SAMPLE_EVERY=1, one commit every cycle, ready=1:
  - 20 PERIODIC records with cycle=k and commits=k, for k=0..19.
  - Then FINAL with cycle=20, commits=20; `halt_cause_o`=MAXCYC.
- No commits, STALL_THRESHOLD=10:
  - `halt_o` rises at cycle 11.
  - FINAL record has commits=0 and cause STALL.
  - `stall_ctr_o` holds at 10.
- FIFO_DEPTH=4, ready=0, SAMPLE_EVERY=1, MAX_CYCLES=10:
  - 3 PERIODIC records are stored and `drop_cnt_o`=7.
  - FINAL is stored in slot 4.
  - Draining yields cycles 0, 1, 2, then 10.
- COMMIT_W=2 with `commit_cnt_i`=2 every cycle and `watch_val_i`={0xDEADBEEF, 0x00000005}:
  - `commits_o` increases by 2 per cycle.
  - Records echo both values exactly.
- Reset asserted at cycle 50 while the FIFO holds 3 entries:
  - After the next edge: counters 0, `state_o`=IDLE, `trace_valid_o`=0, `halt_o`=0.
- With `OOOP_TRACE_STALL_SNAP_EN` defined, STALL_THRESHOLD=10, commits stopping after cycle 5:
  - One STALL_SNAP record with commits=6 when `stall_ctr`=5.
  - When a commit resumes, the trigger re-arms and a second stall episode produces a second snap.
